alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Command front-end that sits directly upstream of the 8-bit ALU.
- Accepts operand/opcode commands on a valid/ready interface and buffers them in a 4-entry FIFO.
- Drives the ALU's opcode/num_1/num_2 inputs, tracks the ALU's 1-cycle registered latency, and captures ans.
- Presents each result, with its opcode echoed, on a back-pressured valid/ready output.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- RES_DEPTH, 2, result buffer entries (fixed at 2 for full throughput)

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  command present
- in_ready  output  1  command accepted when in_valid & in_ready
- in_opcode  input  4  operation: 4'h1 add, 4'h2 sub, 4'h4 mul (low nibbles), 4'h8 mod3 of num_1
- in_num_1  input  8  operand 1
- in_num_2  input  8  operand 2
- alu_opcode  output  4  to ALU opcode
- alu_num_1  output  8  to ALU num_1
- alu_num_2  output  8  to ALU num_2
- alu_ans  input  8  from ALU ans (registered in ALU, valid 1 cycle after issue)
- res_valid  output  1  result available
- res_ready  input  1  result consumed when res_valid & res_ready
- res_data  output  8  result value
- res_opcode  output  4  opcode that produced res_data
- err_illegal  output  1  sticky illegal-opcode flag (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values:
  - in_ready=0 during reset, 1 the cycle after.
  - alu_opcode=4'h0, alu_num_1=0, alu_num_2=0.
  - res_valid=0, res_data=0, res_opcode=0, err_illegal=0.
  - FIFO, in-flight flag and result buffer are emptied.
- Input side:
  - in_ready = FIFO not full.
  - A push on a full FIFO cannot occur.
  - Simultaneous push and pop on a full FIFO is not permitted; in_ready is based on registered count only.
- Issue:
  - Define pop = res_valid & res_ready.
  - Issue in cycle t when the FIFO is non-empty AND (inflight + res_count - pop) < 2.
  - On issue, alu_* are driven combinationally from the FIFO head. The ALU samples them at the posedge ending cycle t; inflight=1 for cycle t+1.
  - When not issuing, alu_opcode=4'h0. The ALU then returns its default 8'hFF, which is ignored. alu_num_* hold their last values.
- Capture:
  - When inflight=1, alu_ans is written into the result buffer at the end of that cycle, with the opcode recorded at issue.
  - Every issued command produces exactly one result.
- Result buffer:
  - 2-entry FIFO; res_valid = res_count != 0; head drives res_data/res_opcode.
  - Capture and pop in the same cycle are both honoured.
- Throughput: with res_ready held 1, one result per cycle sustained.
- Latency: accepted command into empty block -> res_valid 3 cycles later (FIFO write, issue, capture).
- Ordering: results in strict command order.
- Arithmetic: performed by the ALU, 8-bit wrap.
  - add/sub are modulo 256.
  - mul uses num_1[3:0]*num_2[3:0] (max 0xE1).
  - mod3 returns num_1 mod 3.
  - The block never modifies alu_ans.
- Reset mid-operation: in-flight and buffered results are discarded, with no res_valid pulse after reset. The ALU output is ignored until a new issue.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - An accepted command whose opcode is not 4'h1/2/4/8 is dropped at the FIFO input: it is accepted but never issued and produces no result.
  - err_illegal sets the following cycle and stays set until reset.
- Undefined:
  - All opcodes are queued and issued unchanged; the ALU returns 8'hFF for illegal opcodes as a normal result.
  - err_illegal is tied 0.

Test Plan:
- Reset release, res_ready=1; push {1,0x05,0x03} -> res_data=0x08, res_opcode=1, res_valid exactly 3 cycles after accept.
- Back-to-back pushes, res_ready=1: sub 0x03-0x05, mul 0x1F*0x12, mod3 0x0A -> 0xFE, 0x1E, 0x01 in order, one per cycle.
- res_ready=0, push continuously -> 6 commands accepted (2 results buffered, 4 in FIFO), then in_ready=0. Raise res_ready -> all 6 results drain in order, no loss or duplication.
- Toggle res_ready every cycle during a stream of 10 adds (i + 1) -> results 1..10 in order, no gaps.
- Push opcode 4'h3 {0x10,0x20} between two adds:
  - With ILLEGAL_OP_TRAP_EN: only 2 results; err_illegal=1 sticky.
  - Without it: 3 results, the middle one 0xFF; err_illegal=0.
- Assert reset with 3 commands queued and 1 in flight -> next cycle res_valid=0, in_ready=1 after release, no stale result emerges in the following 5 cycles.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command front-end for the 1-cycle registered 8-bit ALU.
// Commands are buffered in a DEPTH-entry FIFO and issued to the ALU only when
// the result buffer is guaranteed to have room. Each ALU answer is captured
// with its opcode and presented in order on a back-pressured result port.
// Optional build macro: ILLEGAL_OP_TRAP_EN (drop illegal opcodes at the FIFO
// input and raise the sticky err_illegal flag).
module alu_issue_ctrl #(
    parameter int DEPTH     = 4,
    parameter int RES_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_opcode,
    input  logic [7:0] in_num_1,
    input  logic [7:0] in_num_2,
    output logic [3:0] alu_opcode,
    output logic [7:0] alu_num_1,
    output logic [7:0] alu_num_2,
    input  logic [7:0] alu_ans,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [3:0] res_opcode,
    output logic       err_illegal
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int RPTR_W = $clog2(RES_DEPTH);
    localparam int RCNT_W = RPTR_W + 1;
    localparam int OCC_W  = RCNT_W + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    // Command FIFO
    cmd_t              fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Issue tracking
    logic              inflight_q;
    logic [3:0]        inflight_op_q;
    logic [7:0]        num_1_q, num_2_q;

    // Result buffer
    logic [7:0]        res_data_q [RES_DEPTH];
    logic [3:0]        res_op_q   [RES_DEPTH];
    logic [RPTR_W-1:0] res_wr_q, res_wr_d;
    logic [RPTR_W-1:0] res_rd_q, res_rd_d;
    logic [RCNT_W-1:0] res_cnt_q, res_cnt_d;

    logic              push, store, issue, pop;
    logic [OCC_W-1:0]  occ;
    cmd_t              head, in_cmd;

    // in_ready is held low during reset so nothing is accepted that reset would discard.
    assign in_ready = ~reset & (cnt_q != FIFO_FULL);
    assign push     = in_valid & in_ready;
    assign in_cmd   = '{op: in_opcode, a: in_num_1, b: in_num_2};
    assign head     = fifo_q[rd_ptr_q];
    assign pop      = res_valid & res_ready;

    // Slots already committed (in flight + buffered), less the one leaving this cycle.
    assign occ   = OCC_W'(inflight_q) + OCC_W'(res_cnt_q) - OCC_W'(pop);
    assign issue = ~reset & (cnt_q != '0) & (occ < OCC_W'(RES_DEPTH));

`ifdef ILLEGAL_OP_TRAP_EN
    logic legal;
    logic err_q;

    assign legal       = in_opcode inside {4'h1, 4'h2, 4'h4, 4'h8};
    assign store       = push & legal;
    assign err_illegal = err_q;

    // Sticky flag for any accepted command carrying an unsupported opcode
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (push & ~legal) begin
            err_q <= 1'b1;
        end
    end
`else
    assign store       = push;
    assign err_illegal = 1'b0;
`endif

    // Next-state for FIFO and result-buffer pointers/counts
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q + CNT_W'(store) - CNT_W'(issue);
        res_wr_d  = res_wr_q;
        res_rd_d  = res_rd_q;
        res_cnt_d = res_cnt_q + RCNT_W'(inflight_q) - RCNT_W'(pop);
        if (store)      wr_ptr_d = wr_ptr_q + 1'b1;
        if (issue)      rd_ptr_d = rd_ptr_q + 1'b1;
        if (inflight_q) res_wr_d = res_wr_q + 1'b1;
        if (pop)        res_rd_d = res_rd_q + 1'b1;
    end

    // Drive the ALU from the FIFO head on issue; idle opcode otherwise
    always_comb begin
        alu_opcode = 4'h0;
        alu_num_1  = num_1_q;
        alu_num_2  = num_2_q;
        if (issue) begin
            alu_opcode = head.op;
            alu_num_1  = head.a;
            alu_num_2  = head.b;
        end
    end

    // Command FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (store) fifo_q[wr_ptr_q] <= in_cmd;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Track the ALU's one-cycle latency and hold the last operands
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q    <= 1'b0;
            inflight_op_q <= 4'h0;
            num_1_q       <= '0;
            num_2_q       <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_op_q <= head.op;
                num_1_q       <= head.a;
                num_2_q       <= head.b;
            end
        end
    end

    // Result buffer: capture the ALU answer while a command is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < RES_DEPTH; i++) begin
                res_data_q[i] <= '0;
                res_op_q[i]   <= '0;
            end
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            res_cnt_q <= '0;
        end else begin
            if (inflight_q) begin
                res_data_q[res_wr_q] <= alu_ans;
                res_op_q[res_wr_q]   <= inflight_op_q;
            end
            res_wr_q  <= res_wr_d;
            res_rd_q  <= res_rd_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    assign res_valid  = (res_cnt_q != '0);
    assign res_data   = res_data_q[res_rd_q];
    assign res_opcode = res_op_q[res_rd_q];

endmodule
